// File: rtl/rv32i_mem_lsu.sv
// RV32I memory stage: issues load/store requests on a req/gnt/rvalid data port,
// formats load data and store strobes, and stalls upstream while an access is in flight.
module rv32i_mem_lsu #(
  parameter int WORD_WTH    = 32,
  parameter int ADDR_WTH    = 32,
  parameter int WB_MUX_WTH  = 2,
  parameter int REG_INX_WTH = 5
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   mem_valid_i,
  input  logic                   mem_rd_i,
  input  logic                   mem_wr_i,
  input  logic [2:0]             mem_funct3_i,
  input  logic                   mem_RegW_EN_i,
  input  logic [WB_MUX_WTH-1:0]  mem_RegW_sel_i,
  input  logic [WORD_WTH-1:0]    mem_alu_res_i,
  input  logic [WORD_WTH-1:0]    mem_st_data_i,
  input  logic [REG_INX_WTH-1:0] mem_rd_inx_i,
  output logic                   dmem_req_o,
  output logic                   dmem_we_o,
  output logic [ADDR_WTH-1:0]    dmem_addr_o,
  output logic [WORD_WTH-1:0]    dmem_wdata_o,
  output logic [3:0]             dmem_wstrb_o,
  input  logic                   dmem_gnt_i,
  input  logic                   dmem_rvalid_i,
  input  logic [WORD_WTH-1:0]    dmem_rdata_i,
  output logic                   mem_stall_o,
  output logic                   mem_misalign_o,
  output logic                   wb_RegW_EN_o,
  output logic [WB_MUX_WTH-1:0]  wb_RegW_sel_o,
  output logic [WORD_WTH-1:0]    wb_reg_wdata1_o,
  output logic [WORD_WTH-1:0]    wb_reg_wdata2_o,
  output logic [REG_INX_WTH-1:0] wb_rd_inx_o
);

  typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

  state_t                 state_q, state_d;
  logic                   dmem_req_q, dmem_req_d;
  logic                   dmem_we_q, dmem_we_d;
  logic [ADDR_WTH-1:0]    dmem_addr_q, dmem_addr_d;
  logic [WORD_WTH-1:0]    dmem_wdata_q, dmem_wdata_d;
  logic [3:0]             dmem_wstrb_q, dmem_wstrb_d;
  logic                   misalign_q, misalign_d;
  logic                   wb_en_q, wb_en_d;
  logic [WB_MUX_WTH-1:0]  wb_sel_q, wb_sel_d;
  logic [WORD_WTH-1:0]    wb_wdata1_q, wb_wdata1_d;
  logic [WORD_WTH-1:0]    wb_wdata2_q, wb_wdata2_d;
  logic [REG_INX_WTH-1:0] wb_rd_q, wb_rd_d;
  logic                   lat_en_q, lat_en_d;
  logic [WB_MUX_WTH-1:0]  lat_sel_q, lat_sel_d;
  logic [REG_INX_WTH-1:0] lat_rd_q, lat_rd_d;
  logic [2:0]             lat_f3_q, lat_f3_d;
  logic [1:0]             lat_off_q, lat_off_d;
  logic [WORD_WTH-1:0]    lat_alu_q, lat_alu_d;

  logic       legal;
  logic [1:0] off;
  logic [7:0] ld_byte;
  logic [15:0] ld_half;
  logic [WORD_WTH-1:0] ld_fmt;

  assign off = mem_alu_res_i[1:0];

  // funct3[1:0] encodes size; funct3[2] is the unsigned flag and is only legal on loads.
  always_comb begin
    legal = 1'b1;
    if (mem_rd_i && mem_wr_i) legal = 1'b0;
    if (mem_funct3_i[1:0] == 2'b11) legal = 1'b0;
    if (mem_funct3_i[2] && (mem_wr_i || mem_funct3_i[1])) legal = 1'b0;
    if (mem_funct3_i[1:0] == 2'b01 && off[0]) legal = 1'b0;
    if (mem_funct3_i[1:0] == 2'b10 && off != 2'b00) legal = 1'b0;
  end

  always_comb begin
    ld_byte = dmem_rdata_i[{lat_off_q, 3'b000} +: 8];
    ld_half = lat_off_q[1] ? dmem_rdata_i[31:16] : dmem_rdata_i[15:0];
    case (lat_f3_q)
      3'b000:  ld_fmt = {{(WORD_WTH-8){ld_byte[7]}}, ld_byte};
      3'b100:  ld_fmt = {{(WORD_WTH-8){1'b0}}, ld_byte};
      3'b001:  ld_fmt = {{(WORD_WTH-16){ld_half[15]}}, ld_half};
      3'b101:  ld_fmt = {{(WORD_WTH-16){1'b0}}, ld_half};
      default: ld_fmt = dmem_rdata_i;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    dmem_req_d   = dmem_req_q;
    dmem_we_d    = dmem_we_q;
    dmem_addr_d  = dmem_addr_q;
    dmem_wdata_d = dmem_wdata_q;
    dmem_wstrb_d = dmem_wstrb_q;
    misalign_d   = 1'b0;
    wb_en_d      = wb_en_q;
    wb_sel_d     = wb_sel_q;
    wb_wdata1_d  = wb_wdata1_q;
    wb_wdata2_d  = wb_wdata2_q;
    wb_rd_d      = wb_rd_q;
    lat_en_d     = lat_en_q;
    lat_sel_d    = lat_sel_q;
    lat_rd_d     = lat_rd_q;
    lat_f3_d     = lat_f3_q;
    lat_off_d    = lat_off_q;
    lat_alu_d    = lat_alu_q;

    case (state_q)
      IDLE: begin
        wb_en_d = 1'b0;
        if (mem_valid_i) begin
          if (!mem_rd_i && !mem_wr_i) begin
            wb_en_d     = mem_RegW_EN_i;
            wb_sel_d    = mem_RegW_sel_i;
            wb_wdata1_d = '0;
            wb_wdata2_d = mem_alu_res_i;
            wb_rd_d     = mem_rd_inx_i;
          end else if (legal) begin
            lat_en_d    = mem_RegW_EN_i;
            lat_sel_d   = mem_RegW_sel_i;
            lat_rd_d    = mem_rd_inx_i;
            lat_f3_d    = mem_funct3_i;
            lat_off_d   = off;
            lat_alu_d   = mem_alu_res_i;
            dmem_req_d  = 1'b1;
            dmem_we_d   = mem_wr_i;
            dmem_addr_d = {mem_alu_res_i[ADDR_WTH-1:2], 2'b00};
            case (mem_funct3_i[1:0])
              2'b00: begin
                dmem_wdata_d = {(WORD_WTH/8){mem_st_data_i[7:0]}};
                dmem_wstrb_d = 4'b0001 << off;
              end
              2'b01: begin
                dmem_wdata_d = {(WORD_WTH/16){mem_st_data_i[15:0]}};
                dmem_wstrb_d = 4'b0011 << off;
              end
              default: begin
                dmem_wdata_d = mem_st_data_i;
                dmem_wstrb_d = 4'b1111;
              end
            endcase
            if (!mem_wr_i) dmem_wstrb_d = 4'b0000;
            state_d = REQ;
          end else begin
            misalign_d = 1'b1;
          end
        end
      end
      REQ: begin
        if (dmem_gnt_i) begin
          dmem_req_d = 1'b0;
          state_d    = RESP;
        end
      end
      RESP: begin
        wb_en_d = 1'b0;
        if (dmem_rvalid_i) begin
          if (!dmem_we_q) begin
            wb_en_d     = lat_en_q;
            wb_sel_d    = lat_sel_q;
            wb_rd_d     = lat_rd_q;
            wb_wdata1_d = ld_fmt;
            wb_wdata2_d = lat_alu_q;
          end
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      dmem_req_q   <= 1'b0;
      dmem_we_q    <= 1'b0;
      dmem_addr_q  <= '0;
      dmem_wdata_q <= '0;
      dmem_wstrb_q <= '0;
      misalign_q   <= 1'b0;
      wb_en_q      <= 1'b0;
      wb_sel_q     <= '0;
      wb_wdata1_q  <= '0;
      wb_wdata2_q  <= '0;
      wb_rd_q      <= '0;
      lat_en_q     <= 1'b0;
      lat_sel_q    <= '0;
      lat_rd_q     <= '0;
      lat_f3_q     <= '0;
      lat_off_q    <= '0;
      lat_alu_q    <= '0;
    end else begin
      state_q      <= state_d;
      dmem_req_q   <= dmem_req_d;
      dmem_we_q    <= dmem_we_d;
      dmem_addr_q  <= dmem_addr_d;
      dmem_wdata_q <= dmem_wdata_d;
      dmem_wstrb_q <= dmem_wstrb_d;
      misalign_q   <= misalign_d;
      wb_en_q      <= wb_en_d;
      wb_sel_q     <= wb_sel_d;
      wb_wdata1_q  <= wb_wdata1_d;
      wb_wdata2_q  <= wb_wdata2_d;
      wb_rd_q      <= wb_rd_d;
      lat_en_q     <= lat_en_d;
      lat_sel_q    <= lat_sel_d;
      lat_rd_q     <= lat_rd_d;
      lat_f3_q     <= lat_f3_d;
      lat_off_q    <= lat_off_d;
      lat_alu_q    <= lat_alu_d;
    end
  end

  assign mem_stall_o     = (state_q != IDLE);
  assign dmem_req_o      = dmem_req_q;
  assign dmem_we_o       = dmem_we_q;
  assign dmem_addr_o     = dmem_addr_q;
  assign dmem_wdata_o    = dmem_wdata_q;
  assign dmem_wstrb_o    = dmem_wstrb_q;
  assign mem_misalign_o  = misalign_q;
  assign wb_RegW_EN_o    = wb_en_q;
  assign wb_RegW_sel_o   = wb_sel_q;
  assign wb_reg_wdata1_o = wb_wdata1_q;
  assign wb_reg_wdata2_o = wb_wdata2_q;
  assign wb_rd_inx_o     = wb_rd_q;

endmodule
